instr_fetch_unit: RTL and testbench

In-order instruction fetch front end for the RISC-V core. It sits directly upstream of the decode stage. It owns the PC, issues word requests to instruction memory, and queues returned instructions with their PCs in a small prefetch buffer. On a redirect from branch resolution it flushes all younger fetches and resumes at the new PC.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RISC-V core constants: datapath width, reset PC, opcodes.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0]  OPC_LOAD         = 7'b000_0011;
    localparam logic [6:0]  OPC_OP_IMM       = 7'b001_0011;
    localparam logic [6:0]  OPC_AUIPC        = 7'b001_0111;
    localparam logic [6:0]  OPC_STORE        = 7'b010_0011;
    localparam logic [6:0]  OPC_OP           = 7'b011_0011;
    localparam logic [6:0]  OPC_LUI          = 7'b011_0111;
    localparam logic [6:0]  OPC_BRANCH       = 7'b110_0011;
    localparam logic [6:0]  OPC_JALR         = 7'b110_0111;
    localparam logic [6:0]  OPC_JAL          = 7'b110_1111;
    localparam logic [6:0]  OPC_SYSTEM       = 7'b111_0011;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Fetch-unit bundle: imem request/response, redirect and decode side.
// Revision : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with count and single-cycle flush.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_pop_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : In-order fetch front end: PC, credit-limited imem requests, prefetch queue, redirect flush.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::DEFAULT_RESET_PC)
) (
    input wire logic          clk,
    input wire logic          rst,
    instr_fetch_unit_if.master bus
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = XLEN + 32;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_pending;
    logic [CW-1:0]   r_drop;

    logic            w_req_fire;
    logic            w_rsp;
    logic            w_out_fire;
    logic            w_discard;
    logic [CW:0]     w_credit_used;
    logic [XLEN-1:0] w_tag;
    logic [OW-1:0]   w_out_data;
    logic            w_out_empty;
    logic [CW-1:0]   w_out_count;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [CW-1:0]   w_tag_count;
    logic            w_out_full;
    logic            w_unused;

    assign w_credit_used      = {1'b0, r_pending} + {1'b0, w_out_count};
    assign bus.imem_req_valid = !rst && (w_credit_used < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = {r_pc[XLEN-1:2], 2'b00};

    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp      = bus.imem_rsp_valid;
    assign w_out_fire = bus.out_valid && bus.out_ready;
    // A redirect kills the response of its own cycle as well as older stale ones.
    assign w_discard  = bus.redirect_valid || (r_drop != '0);

    assign bus.out_valid = !rst && !w_out_empty;
    assign bus.out_pc    = bus.out_valid ? w_out_data[OW-1:32] : '0;
    assign bus.out_instr = bus.out_valid ? w_out_data[31:0]    : '0;

    assign w_unused = ^{w_tag_full, w_tag_empty, w_tag_count, w_out_full, bus.redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_pending <= '0;
            r_drop    <= '0;
        end else begin
            r_pending <= r_pending + CW'(w_req_fire) - CW'(w_rsp);
            if (bus.redirect_valid) begin
                r_pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                r_drop <= r_pending + CW'(w_req_fire) - CW'(w_rsp);
            end else begin
                if (w_req_fire)                  r_pc   <= r_pc + XLEN'(4);
                if (w_rsp && (r_drop != '0))     r_drop <= r_drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (1'b0),
        .i_push      (w_req_fire),
        .i_push_data (r_pc),
        .i_pop       (w_rsp),
        .o_pop_data  (w_tag),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    fetch_fifo #(
        .WIDTH (OW),
        .DEPTH (DEPTH)
    ) u_out_q (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_rsp && !w_discard),
        .i_push_data ({w_tag, bus.imem_rsp_data}),
        .i_pop       (w_out_fire),
        .o_pop_data  (w_out_data),
        .o_full      (w_out_full),
        .o_empty     (w_out_empty),
        .o_count     (w_out_count)
    );
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Scoreboard bench for instr_fetch_unit with an in-order imem model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    req_t        infl[$];
    out_t        sb[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    logic [31:0] exp_pc   = RESET_PC;

    logic        rst_req  = 1'b1;
    logic        rd_req   = 1'b0;
    logic [31:0] rd_pc    = '0;
    logic        ordy     = 1'b1;
    logic        rdy_rand = 1'b0;
    logic        lat_rand = 1'b0;
    int          lat      = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic rsp_v;
        int   rsp_ep;
        logic [31:0] rsp_addr;
        logic req_fire;
        int   pend;
        @(negedge clk);
        rsp_v    = 1'b0;
        rsp_ep   = 0;
        rsp_addr = '0;
        rst      = rst_req;
        if (!rst_req && infl.size() > 0 && infl[0].due <= cyc) begin
            rsp_v    = 1'b1;
            rsp_ep   = infl[0].ep;
            rsp_addr = infl[0].addr;
            void'(infl.pop_front());
        end
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_v ? mem_word(rsp_addr) : 32'h0;
        bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.redirect_valid = rd_req;
        bus.redirect_pc    = rd_pc;
        bus.out_ready      = ordy;
        #1;
        if (rst_req) begin
            check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_instr", 64'(bus.out_instr), 64'd0);
            check("rst_out_pc",    64'(bus.out_pc),    64'd0);
            infl.delete();
            sb.delete();
            exp_pc = RESET_PC;
            epoch++;
        end else begin
            pend = infl.size() + (rsp_v ? 1 : 0);
            check("no_overflow", 64'(pend + sb.size() <= DEPTH), 64'd1);
            check("req_valid", 64'(bus.imem_req_valid), 64'(pend + sb.size() < DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            if (bus.out_valid && sb.size() != 0) begin
                check("out_pc",    64'(bus.out_pc),    64'(sb[0].pc));
                check("out_instr", 64'(bus.out_instr), 64'(sb[0].instr));
                if (bus.out_ready) void'(sb.pop_front());
            end
            req_fire = bus.imem_req_valid && bus.imem_req_ready;
            if (req_fire) begin
                check("req_addr", 64'(bus.imem_req_addr), 64'(exp_pc));
                infl.push_back('{addr: bus.imem_req_addr,
                                 due:  cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat),
                                 ep:   epoch});
            end
            if (rsp_v && !rd_req && rsp_ep == epoch)
                sb.push_back('{pc: rsp_addr, instr: mem_word(rsp_addr)});
            if (rd_req) begin
                sb.delete();
                epoch++;
                exp_pc = {rd_pc[31:2], 2'b00};
            end else if (req_fire) begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        rd_req = 1'b1;
        rd_pc  = pc;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        repeat (3) step();
        rst_req = 1'b0;

        // Streaming with 1-cycle memory, decode always ready
        repeat (20) step();

        // Decode stall: credit limits to DEPTH outstanding, then drains in order
        ordy = 1'b0;
        repeat (12) step();
        ordy = 1'b1;
        repeat (10) step();

        // Redirect with longer memory latency and stale responses in flight
        lat = 3;
        repeat (12) step();
        redirect_to(32'h0000_0040);
        repeat (15) step();

        // Redirect colliding with response, request and output handshakes
        lat = 1;
        repeat (10) step();
        redirect_to(32'h0000_0080);
        repeat (10) step();

        // Unaligned redirect target
        redirect_to(32'h0000_0042);
        repeat (10) step();

        // Back-to-back redirects
        redirect_to(32'h0000_0100);
        redirect_to(32'h0000_0200);
        repeat (12) step();

        // Randomised traffic: memory stalls, variable latency, decode stalls, redirects
        rdy_rand = 1'b1;
        lat_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ordy   = ($urandom_range(0, 3) != 0);
            rd_req = ($urandom_range(0, 19) == 0);
            rd_pc  = 32'($urandom_range(0, 4095));
            step();
        end
        rd_req   = 1'b0;

        // Reset mid-operation with a filled output queue and requests pending
        rdy_rand = 1'b0;
        lat_rand = 1'b0;
        lat      = 3;
        ordy     = 1'b0;
        repeat (8) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        ordy    = 1'b1;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
